back_bus_producer: RTL and testbench

// Builds the MEM and WB stages' 38-bit register back-buses {regWrite,Wd[31:0],rd[4:0]} consumed by the operand-forwarding unit.

---
 rtl/back_bus_producer_if.sv | 58 +++++
 rtl/back_bus_producer.sv | 158 +++++++++++++++
 tb/tb_back_bus_producer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/back_bus_producer_if.sv
`default_nettype none
// ============================================================================
// Module      : back_bus_producer_if
// Description : Bundles the signals around the MEM/WB back-bus producer.
//               EX-stage offer and ID source registers, the data-memory
//               load port, the two 38-bit back-buses with their use flags,
//               the register-file write port, the stall and the error pulse.
//               master : producer side (back_bus_producer)
//               slave  : pipeline / memory / forwarding side
// Revision    : 1.0  initial release
// ============================================================================
interface back_bus_producer_if #(
    parameter int DW = 32
);
    // EX stage offer
    logic          ex_valid;
    logic          ex_regwrite;
    logic          ex_memread;
    logic [4:0]    ex_rd;
    logic [DW-1:0] ex_result;
    logic          ex_ready;
    // Source registers of the instruction in ID/EX
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          stall;
    // Data memory load port
    logic          dmem_req;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_rvalid;
    // Back-buses {regwrite, wd, rd} for the forwarding unit
    logic [DW+5:0] MEM_BACK;
    logic [DW+5:0] WB_BACK;
    logic          USE_MEM_BACK;
    logic          USE_WB_BACK;
    // Register-file write port
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [DW-1:0] rf_wd;
    logic          err;

    modport master (
        input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_result,
        input  id_rs, id_rt, dmem_rdata, dmem_rvalid,
        output ex_ready, stall, dmem_req, dmem_addr,
        output MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK,
        output rf_we, rf_wa, rf_wd, err
    );

    modport slave (
        output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_result,
        output id_rs, id_rt, dmem_rdata, dmem_rvalid,
        input  ex_ready, stall, dmem_req, dmem_addr,
        input  MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK,
        input  rf_we, rf_wa, rf_wd, err
    );
endinterface
`default_nettype wire

// File: rtl/back_bus_producer.sv
`default_nettype none
// ============================================================================
// Module      : back_bus_producer
// Description : MEM and WB pipeline registers plus the load wait FSM.
//               Produces the MEM/WB back-buses {regwrite, wd, rd} for the
//               operand-forwarding unit, drives the register-file write port
//               from the WB stage and raises the load stall toward IF/ID/EX.
// Ports       : clk    - clock, all state on rising edge
//               rst_n  - synchronous active-low reset
//               bus    - back_bus_producer_if.master (EX offer, ID sources,
//                        dmem load port, back-buses, rf write, stall, err)
// Revision    : 1.0  initial release
// ============================================================================
module back_bus_producer #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    back_bus_producer_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_EMPTY     = 2'd0,
        S_ALU       = 2'd1,
        S_LOAD_WAIT = 2'd2,
        S_LOAD_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mem_regwrite_q, mem_regwrite_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [4:0]    mem_rd_q, mem_rd_d;
    logic [DW-1:0] dmem_addr_q, dmem_addr_d;

    logic          wb_regwrite_q, wb_regwrite_d;
    logic [DW-1:0] wb_wd_q, wb_wd_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          use_wb_q, use_wb_d;

    logic w_in_wait;
    logic w_mem_final;
    logic w_accept;
    logic w_timeout;
    logic w_load_use;

    assign w_in_wait   = (state_q == S_LOAD_WAIT);
    assign w_mem_final = (state_q == S_ALU) || (state_q == S_LOAD_DONE);
    assign w_accept    = bus.ex_valid && !w_in_wait;
    // Returned data on the last allowed cycle takes priority over the timeout.
    assign w_timeout   = w_in_wait && !bus.dmem_rvalid && (cnt_q == C_CNT_LAST);

    // Consumer in ID/EX reads the register the pending load will write.
    // Every LOAD_WAIT cycle already stalls, so this term is covered by
    // w_in_wait; it is kept explicit to document the hazard being resolved.
    assign w_load_use  = w_in_wait && (mem_rd_q != 5'd0) &&
                         ((mem_rd_q == bus.id_rs) || (mem_rd_q == bus.id_rt));

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        mem_regwrite_d = mem_regwrite_q;
        mem_wd_d       = mem_wd_q;
        mem_rd_d       = mem_rd_q;
        dmem_addr_d    = dmem_addr_q;
        wb_regwrite_d  = 1'b0;
        wb_wd_d        = wb_wd_q;
        wb_rd_d        = wb_rd_q;
        use_wb_d       = 1'b0;

        // WB takes MEM only when MEM holds a final result; otherwise a bubble.
        if (w_mem_final) begin
            wb_regwrite_d = mem_regwrite_q;
            wb_wd_d       = mem_wd_q;
            wb_rd_d       = mem_rd_q;
            use_wb_d      = 1'b1;
        end

        case (state_q)
            S_LOAD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.dmem_rvalid) begin
                    mem_wd_d = bus.dmem_rdata;
                    state_d  = S_LOAD_DONE;
                    cnt_d    = '0;
                end else if (w_timeout) begin
                    mem_wd_d = '0;
                    state_d  = S_LOAD_DONE;
                    cnt_d    = '0;
                end
            end
            default: begin
                if (w_accept) begin
                    mem_regwrite_d = bus.ex_regwrite;
                    mem_wd_d       = bus.ex_result;
                    mem_rd_d       = bus.ex_rd;
                    if (bus.ex_memread) begin
                        dmem_addr_d = bus.ex_result;
                        state_d     = S_LOAD_WAIT;
                    end else begin
                        state_d     = S_ALU;
                    end
                end else begin
                    // Empty MEM stage must not advertise a register write.
                    mem_regwrite_d = 1'b0;
                    state_d        = S_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_EMPTY;
            cnt_q          <= '0;
            mem_regwrite_q <= 1'b0;
            mem_wd_q       <= '0;
            mem_rd_q       <= 5'd0;
            dmem_addr_q    <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_wd_q        <= '0;
            wb_rd_q        <= 5'd0;
            use_wb_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_wd_q       <= mem_wd_d;
            mem_rd_q       <= mem_rd_d;
            dmem_addr_q    <= dmem_addr_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_wd_q        <= wb_wd_d;
            wb_rd_q        <= wb_rd_d;
            use_wb_q       <= use_wb_d;
        end
    end

    assign bus.ex_ready     = !w_in_wait;
    assign bus.stall        = w_in_wait || w_load_use;
    assign bus.dmem_req     = w_in_wait;
    assign bus.dmem_addr    = dmem_addr_q;
    assign bus.MEM_BACK     = {mem_regwrite_q, mem_wd_q, mem_rd_q};
    assign bus.WB_BACK      = {wb_regwrite_q, wb_wd_q, wb_rd_q};
    assign bus.USE_MEM_BACK = w_mem_final;
    assign bus.USE_WB_BACK  = use_wb_q;
    // r0 is hard-wired zero: carried on the buses but never written.
    assign bus.rf_we        = wb_regwrite_q && use_wb_q && (wb_rd_q != 5'd0);
    assign bus.rf_wa        = wb_rd_q;
    assign bus.rf_wd        = wb_wd_q;
    assign bus.err          = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_back_bus_producer.sv
`default_nettype none
// ============================================================================
// Module      : tb_back_bus_producer
// Description : Scoreboard bench for back_bus_producer. Stimulus pushes the
//               expected MEM and WB back-bus contents of each instruction;
//               a monitor pops and compares whenever the DUT flags
//               USE_MEM_BACK / USE_WB_BACK.
// Revision    : 1.0  initial release
// ============================================================================
module tb_back_bus_producer;

    typedef struct packed {
        logic [37:0] back;
        logic        we;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en = 1'b0;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [37:0] mem_q[$];
    wb_exp_t     wb_q[$];

    back_bus_producer_if #(.DW(32)) bus ();

    back_bus_producer #(.DW(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.USE_MEM_BACK) begin
                if (mem_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL mem_unexpected: got MEM_BACK %h expected no output", bus.MEM_BACK);
                end else begin
                    chk("mem_back", 64'(bus.MEM_BACK), 64'(mem_q.pop_front()));
                end
            end
            if (bus.USE_WB_BACK) begin
                if (wb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL wb_unexpected: got WB_BACK %h expected no output", bus.WB_BACK);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_back", 64'(bus.WB_BACK), 64'(e.back));
                    chk("rf_we",   64'(bus.rf_we),   64'(e.we));
                    chk("rf_wa",   64'(bus.rf_wa),   64'(e.back[4:0]));
                    chk("rf_wd",   64'(bus.rf_wd),   64'(e.back[36:5]));
                end
            end else begin
                chk("rf_we_idle", 64'(bus.rf_we), 64'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_alu(input logic rw, input logic [4:0] rd,
                             input logic [31:0] res, input logic we_exp);
        wb_exp_t e;
        mem_q.push_back({rw, res, rd});
        e.back = {rw, res, rd};
        e.we   = we_exp;
        wb_q.push_back(e);
        bus.ex_valid    = 1'b1;
        bus.ex_regwrite = rw;
        bus.ex_memread  = 1'b0;
        bus.ex_rd       = rd;
        bus.ex_result   = res;
        @(negedge clk);
        bus.ex_valid    = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input int lat,
                           input logic give, input logic [31:0] data,
                           input logic [31:0] exp_wd, input logic exp_we, input logic exp_err,
                           input logic [4:0] rs, input logic [4:0] rt);
        wb_exp_t e;
        mem_q.push_back({1'b1, exp_wd, rd});
        e.back = {1'b1, exp_wd, rd};
        e.we   = exp_we;
        wb_q.push_back(e);
        bus.ex_valid    = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_memread  = 1'b1;
        bus.ex_rd       = rd;
        bus.ex_result   = addr;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        @(negedge clk);
        bus.ex_valid    = 1'b0;
        bus.ex_memread  = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (i == lat && give) begin
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = data;
            end
            #1;
            chk("ld_dmem_req",  64'(bus.dmem_req),      64'(1));
            chk("ld_stall",     64'(bus.stall),         64'(1));
            chk("ld_ex_ready",  64'(bus.ex_ready),      64'(0));
            chk("ld_use_mem",   64'(bus.USE_MEM_BACK),  64'(0));
            chk("ld_dmem_addr", 64'(bus.dmem_addr),     64'(addr));
            chk("ld_mem_wd",    64'(bus.MEM_BACK[36:5]), 64'(addr));
            chk("ld_err",       64'(bus.err),           64'((i == lat) && exp_err));
            @(negedge clk);
            bus.dmem_rvalid = 1'b0;
        end
        chk("ld_done_req",   64'(bus.dmem_req), 64'(0));
        chk("ld_done_stall", 64'(bus.stall),    64'(0));
        chk("ld_done_ready", 64'(bus.ex_ready), 64'(1));
        bus.id_rs = 5'd0;
        bus.id_rt = 5'd0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.ex_valid    = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_memread  = 1'b0;
        bus.ex_rd       = 5'd3;
        bus.ex_result   = 32'hFFFF;
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
        bus.dmem_rdata  = 32'd0;
        bus.dmem_rvalid = 1'b0;

        // Reset with ex_valid held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_back", 64'(bus.MEM_BACK),     64'(0));
        chk("rst_wb_back",  64'(bus.WB_BACK),      64'(0));
        chk("rst_use_mem",  64'(bus.USE_MEM_BACK), 64'(0));
        chk("rst_use_wb",   64'(bus.USE_WB_BACK),  64'(0));
        chk("rst_dmem_req", 64'(bus.dmem_req),     64'(0));
        chk("rst_stall",    64'(bus.stall),        64'(0));
        chk("rst_rf_we",    64'(bus.rf_we),        64'(0));
        chk("rst_err",      64'(bus.err),          64'(0));
        chk("rst_dmem_addr",64'(bus.dmem_addr),    64'(0));
        rst_n        = 1'b1;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        chk("post_rst_ready", 64'(bus.ex_ready),     64'(1));
        chk("post_rst_usemem",64'(bus.USE_MEM_BACK), 64'(0));

        // ALU ops: single, r0, back-to-back
        issue_alu(1'b1, 5'd3, 32'h1234, 1'b1);
        repeat (2) @(negedge clk);
        issue_alu(1'b1, 5'd0, 32'hBEEF, 1'b0);
        repeat (2) @(negedge clk);
        issue_alu(1'b1, 5'd5, 32'h11, 1'b1);
        issue_alu(1'b0, 5'd6, 32'h22, 1'b0);
        repeat (2) @(negedge clk);

        // Loads: 3-cycle latency, load-use, r0 load, timeout, data on timeout cycle
        do_load(5'd5, 32'h40, 3,  1'b1, 32'hCAFE, 32'hCAFE, 1'b1, 1'b0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        do_load(5'd7, 32'h80, 2,  1'b1, 32'h1111, 32'h1111, 1'b1, 1'b0, 5'd1, 5'd7);
        do_load(5'd0, 32'h84, 1,  1'b1, 32'h2222, 32'h2222, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        do_load(5'd8, 32'h90, 15, 1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 5'd0, 5'd0);
        issue_alu(1'b1, 5'd4, 32'h55, 1'b1);
        repeat (2) @(negedge clk);
        do_load(5'd9, 32'h94, 15, 1'b1, 32'h77,   32'h77,   1'b1, 1'b0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // rvalid outside LOAD_WAIT is ignored
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hDEAD;
        #1;
        chk("stray_rv_err", 64'(bus.err), 64'(0));
        repeat (2) @(negedge clk);
        chk("stray_rv_use", 64'(bus.USE_MEM_BACK), 64'(0));
        chk("stray_rv_req", 64'(bus.dmem_req),     64'(0));
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a load
        bus.ex_valid    = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_memread  = 1'b1;
        bus.ex_rd       = 5'd10;
        bus.ex_result   = 32'hA0;
        @(negedge clk);
        bus.ex_valid    = 1'b0;
        bus.ex_memread  = 1'b0;
        @(negedge clk);
        chk("midld_req", 64'(bus.dmem_req), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midld_rst_req",   64'(bus.dmem_req),     64'(0));
        chk("midld_rst_usemem",64'(bus.USE_MEM_BACK), 64'(0));
        chk("midld_rst_usewb", 64'(bus.USE_WB_BACK),  64'(0));
        chk("midld_rst_rfwe",  64'(bus.rf_we),        64'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("mem_q_drained", 64'(mem_q.size()), 64'(0));
        chk("wb_q_drained",  64'(wb_q.size()),  64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
